cursor_button_pulser: RTL

- Conditions the four raw direction push-buttons (up/down/left/right) into the single-cycle step pulses consumed by the manual projector-correction cursor logic.
- Each pulse moves the selected corner by one 8-pixel step.
- Functions: synchronises, debounces, priority-selects one direction, emits one pulse on press, then auto-repeats while held.
- Sits between the labkit button inputs and the corner-adjust UI, in the pixel clock domain.

---
 rtl/cursor_button_pulser.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/cursor_button_pulser.sv
// cursor_button_pulser: turns four raw direction buttons into one-cycle
// cursor step pulses with debounce, priority select and auto-repeat.
//
// Ports:
//   clk            rising-edge clock (pixel clock domain)
//   reset          asynchronous, active-high
//   enable         high = pulses permitted; low = FSM held idle
//   btn_*_raw      raw active-high buttons, asynchronous to clk
//   up/down/left/right  registered one-cycle step pulses (at most one high)
//   held           registered; high while any debounced button is pressed
module cursor_button_pulser #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_DELAY    = 26000000,
    parameter int REPEAT_PERIOD   = 6500000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic held
);

    localparam int NBTN = 4;

    // Button index order used throughout: 0 up, 1 down, 2 left, 3 right
    localparam int IDX_UP    = 0;
    localparam int IDX_DOWN  = 1;
    localparam int IDX_LEFT  = 2;
    localparam int IDX_RIGHT = 3;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    logic [NBTN-1:0]  raw;
    logic [NBTN-1:0]  sync1;
    logic [NBTN-1:0]  sync2;
    logic [NBTN-1:0]  stable;
    logic [CNT_W-1:0] db_cnt [NBTN];

    dir_t             sel;
    dir_t             cur;
    dir_t             cur_n;
    dir_t             fire;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] rpt_cnt;
    logic [CNT_W-1:0] rpt_cnt_n;
    logic [CNT_W-1:0] rpt_last;
    logic [NBTN-1:0]  pulse_n;

    assign raw[IDX_UP]    = btn_up_raw;
    assign raw[IDX_DOWN]  = btn_down_raw;
    assign raw[IDX_LEFT]  = btn_left_raw;
    assign raw[IDX_RIGHT] = btn_right_raw;

    // Two-flop synchroniser for the asynchronous button inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: the counter only runs while the synchronised input
    // disagrees with the accepted state, so any bounce restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Priority: down > up > left > right
    always_comb begin
        sel = DIR_NONE;
        priority case (1'b1)
            stable[IDX_DOWN]:  sel = DIR_DOWN;
            stable[IDX_UP]:    sel = DIR_UP;
            stable[IDX_LEFT]:  sel = DIR_LEFT;
            stable[IDX_RIGHT]: sel = DIR_RIGHT;
            default:           sel = DIR_NONE;
        endcase
    end

    assign rpt_last = (state == DELAY) ? DLY_LAST : PER_LAST;

    // Next-state logic; fire names the direction to pulse this edge
    always_comb begin
        state_n   = state;
        cur_n     = cur;
        rpt_cnt_n = rpt_cnt;
        fire      = DIR_NONE;
        unique case (state)
            IDLE: begin
                if (enable && sel != DIR_NONE) begin
                    fire      = sel;
                    cur_n     = sel;
                    rpt_cnt_n = '0;
                    state_n   = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (!enable || sel == DIR_NONE) begin
                    cur_n     = DIR_NONE;
                    rpt_cnt_n = '0;
                    state_n   = IDLE;
                end else if (sel != cur) begin
                    // A new direction restarts the initial repeat delay
                    fire      = sel;
                    cur_n     = sel;
                    rpt_cnt_n = '0;
                    state_n   = DELAY;
                end else if (rpt_cnt == rpt_last) begin
                    fire      = cur;
                    rpt_cnt_n = '0;
                    state_n   = REPEAT;
                end else begin
                    rpt_cnt_n = rpt_cnt + 1'b1;
                end
            end
            default: begin
                cur_n     = DIR_NONE;
                rpt_cnt_n = '0;
                state_n   = IDLE;
            end
        endcase
    end

    always_comb begin
        pulse_n = '0;
        unique case (fire)
            DIR_UP:    pulse_n[IDX_UP]    = 1'b1;
            DIR_DOWN:  pulse_n[IDX_DOWN]  = 1'b1;
            DIR_LEFT:  pulse_n[IDX_LEFT]  = 1'b1;
            DIR_RIGHT: pulse_n[IDX_RIGHT] = 1'b1;
            default:   pulse_n = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cur     <= DIR_NONE;
            rpt_cnt <= '0;
        end else begin
            state   <= state_n;
            cur     <= cur_n;
            rpt_cnt <= rpt_cnt_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up    <= 1'b0;
            down  <= 1'b0;
            left  <= 1'b0;
            right <= 1'b0;
            held  <= 1'b0;
        end else begin
            up    <= pulse_n[IDX_UP];
            down  <= pulse_n[IDX_DOWN];
            left  <= pulse_n[IDX_LEFT];
            right <= pulse_n[IDX_RIGHT];
            held  <= |stable;
        end
    end

endmodule
